// File: rtl/uart_receiver_center_pkg.sv
// Shared definitions for the oversampled UART receiver and its Avalon-MM word writer.
package uart_receiver_center_pkg;

   localparam int OVERSAMPLE_DEFAULT  = 16;
   localparam int SYNC_STAGES_DEFAULT = 2;

   // 8N1 framing
   localparam int   DATA_BITS       = 8;
   localparam logic START_BIT_LEVEL = 1'b0;
   localparam logic STOP_BIT_LEVEL  = 1'b1;
   localparam logic IDLE_LEVEL      = 1'b1;

   typedef enum logic [1:0] {
      R_IDLE,
      R_START,
      R_DATA,
      R_STOP
   } rx_state_t;

   typedef enum logic [1:0] {
      W_IDLE,
      W_COLLECT,
      W_WRITE
   } wr_state_t;

   function automatic logic [3:0] lane_mask(input logic [1:0] lane);
      return 4'b0001 << lane;
   endfunction

endpackage

// File: rtl/uart_receiver_center_deserializer.sv
// Line synchroniser plus 8N1 receiver FSM; emits one-clk byte_valid / frame_err pulses.
module uart_rx_deserializer
   import uart_receiver_center_pkg::*;
#(
   parameter int OVERSAMPLE  = OVERSAMPLE_DEFAULT,
   parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       uart_rx,
   output logic [7:0] data_byte,
   output logic       byte_valid,
   output logic       frame_err
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);
   localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   rx_s;

   rx_state_t   state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [2:0]  bit_reg, bit_next;
   logic [7:0]  shift_reg, shift_next;
   logic        valid_reg, valid_next;
   logic        ferr_reg, ferr_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_reg <= '1;
      end else begin
         for (int i = SYNC_STAGES - 1; i > 0; i--) begin
            sync_reg[i] <= sync_reg[i-1];
         end
         sync_reg[0] <= uart_rx;
      end
   end

   assign rx_s = sync_reg[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= R_IDLE;
         cnt_reg   <= '0;
         bit_reg   <= '0;
         shift_reg <= '0;
         valid_reg <= 1'b0;
         ferr_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         bit_reg   <= bit_next;
         shift_reg <= shift_next;
         valid_reg <= valid_next;
         ferr_reg  <= ferr_next;
      end
   end

   // The start bit is re-checked half a bit after the falling edge, which
   // aligns every later sample (one full bit apart) to the middle of its bit.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      bit_next   = bit_reg;
      shift_next = shift_reg;
      valid_next = 1'b0;
      ferr_next  = 1'b0;
      if (tick) begin
         case (state_reg)
            R_IDLE: begin
               if (rx_s == START_BIT_LEVEL) begin
                  state_next = R_START;
                  cnt_next   = '0;
               end
            end
            R_START: begin
               if (cnt_reg == HALF_LAST) begin
                  cnt_next   = '0;
                  bit_next   = '0;
                  state_next = (rx_s == START_BIT_LEVEL) ? R_DATA : R_IDLE;
               end else begin
                  cnt_next = cnt_reg + CW'(1);
               end
            end
            R_DATA: begin
               if (cnt_reg == FULL_LAST) begin
                  cnt_next   = '0;
                  shift_next = {rx_s, shift_reg[7:1]};
                  bit_next   = bit_reg + 3'd1;
                  if (bit_reg == LAST_BIT) begin
                     state_next = R_STOP;
                  end
               end else begin
                  cnt_next = cnt_reg + CW'(1);
               end
            end
            R_STOP: begin
               if (cnt_reg == FULL_LAST) begin
                  cnt_next   = '0;
                  state_next = R_IDLE;
                  if (rx_s == STOP_BIT_LEVEL) begin
                     valid_next = 1'b1;
                  end else begin
                     ferr_next = 1'b1;
                  end
               end else begin
                  cnt_next = cnt_reg + CW'(1);
               end
            end
            default: state_next = R_IDLE;
         endcase
      end
   end

   assign data_byte  = shift_reg;
   assign byte_valid = valid_reg;
   assign frame_err  = ferr_reg;

endmodule

// File: rtl/uart_receiver_center.sv
// UART receive job engine: packs received bytes into 32-bit words and writes
// them over an Avalon-MM master across an inclusive, wrapping byte range.
module uart_receiver_center
   import uart_receiver_center_pkg::*;
#(
   parameter int OVERSAMPLE  = OVERSAMPLE_DEFAULT,
   parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick,
   input  logic        uart_rx,
   input  logic        control_recv_start,
   input  logic [15:0] control_recv_start_addr,
   input  logic [15:0] control_recv_stop_addr,
   output logic        control_recv_work,
   output logic        control_recv_err,
   output logic        avm_m1_write,
   output logic [15:0] avm_m1_address,
   output logic [31:0] avm_m1_writedata,
   output logic [3:0]  avm_m1_byteenable,
   input  logic        avm_m1_waitrequest
);

   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       rx_ferr;

   uart_rx_deserializer #(
      .OVERSAMPLE  (OVERSAMPLE),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_deser (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .uart_rx    (uart_rx),
      .data_byte  (rx_byte),
      .byte_valid (rx_valid),
      .frame_err  (rx_ferr)
   );

   wr_state_t   state_reg, state_next;
   logic [15:0] addr_reg, addr_next;
   logic [15:0] stop_reg, stop_next;
   logic [31:0] lanes_reg, lanes_next;
   logic [3:0]  be_reg, be_next;
   logic [7:0]  skid_reg, skid_next;
   logic        skid_valid_reg, skid_valid_next;
   logic        err_reg, err_next;
   logic        work_reg, work_next;

   logic        have_byte;
   logic [7:0]  cur_byte;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= W_IDLE;
         addr_reg       <= '0;
         stop_reg       <= '0;
         lanes_reg      <= '0;
         be_reg         <= '0;
         skid_reg       <= '0;
         skid_valid_reg <= 1'b0;
         err_reg        <= 1'b0;
         work_reg       <= 1'b0;
      end else begin
         state_reg      <= state_next;
         addr_reg       <= addr_next;
         stop_reg       <= stop_next;
         lanes_reg      <= lanes_next;
         be_reg         <= be_next;
         skid_reg       <= skid_next;
         skid_valid_reg <= skid_valid_next;
         err_reg        <= err_next;
         work_reg       <= work_next;
      end
   end

   // A held skid byte is older than any live byte, so it is consumed first.
   assign have_byte = skid_valid_reg | rx_valid;
   assign cur_byte  = skid_valid_reg ? skid_reg : rx_byte;

   always_comb begin
      state_next      = state_reg;
      addr_next       = addr_reg;
      stop_next       = stop_reg;
      lanes_next      = lanes_reg;
      be_next         = be_reg;
      skid_next       = skid_reg;
      skid_valid_next = skid_valid_reg;
      err_next        = err_reg;
      work_next       = work_reg;

      case (state_reg)
         W_IDLE: begin
            skid_valid_next = 1'b0;
            if (control_recv_start) begin
               addr_next  = control_recv_start_addr;
               stop_next  = control_recv_stop_addr;
               lanes_next = '0;
               be_next    = '0;
               err_next   = 1'b0;
               work_next  = 1'b1;
               state_next = W_COLLECT;
            end
         end
         W_COLLECT: begin
            if (skid_valid_reg) begin
               skid_valid_next = rx_valid;
               skid_next       = rx_valid ? rx_byte : skid_reg;
            end
            if (have_byte) begin
               for (int i = 0; i < 4; i++) begin
                  if (addr_reg[1:0] == 2'(i)) begin
                     lanes_next[i*8 +: 8] = cur_byte;
                  end
               end
               be_next = be_reg | lane_mask(addr_reg[1:0]);
               if (addr_reg == stop_reg || addr_reg[1:0] == 2'b11) begin
                  state_next = W_WRITE;
               end else begin
                  addr_next = addr_reg + 16'd1;
               end
            end
         end
         W_WRITE: begin
            if (rx_valid) begin
               if (!skid_valid_reg) begin
                  skid_next       = rx_byte;
                  skid_valid_next = 1'b1;
               end else begin
                  err_next = 1'b1;
               end
            end
            if (!avm_m1_waitrequest) begin
               if (addr_reg == stop_reg) begin
                  state_next      = W_IDLE;
                  work_next       = 1'b0;
                  skid_valid_next = 1'b0;
               end else begin
                  addr_next  = addr_reg + 16'd1;
                  be_next    = '0;
                  lanes_next = '0;
                  state_next = W_COLLECT;
               end
            end
         end
         default: state_next = W_IDLE;
      endcase

      if (rx_ferr) begin
         err_next = 1'b1;
      end
   end

   assign control_recv_work = work_reg;
   assign control_recv_err  = err_reg;
   assign avm_m1_write      = (state_reg == W_WRITE);
   assign avm_m1_address    = {addr_reg[15:2], 2'b00};
   assign avm_m1_writedata  = lanes_reg;
   assign avm_m1_byteenable = be_reg;

endmodule
